mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store unit between the CPU memory stage and the ready/valid block-RAM wrapper (word-wide, no byte enables). Takes byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests and turns them into word accesses. Loads get lane extraction plus sign or zero extension. Sub-word stores use read-modify-write. Byte order is little-endian.

Parameters:
ADDR_WIDTH, 10, word-address width of the downstream RAM (RAM holds 1<<ADDR_WIDTH words)
DATA_WIDTH, 32, data width; the only supported value is 32

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_req_valid  in  1  CPU request valid
o_req_ready  out  1  LSU can accept a request
i_req_addr  in  32  byte address
i_req_we  in  1  1=store, 0=load
i_req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
i_req_unsigned  in  1  load zero-extends (LBU/LHU)
i_req_wdata  in  32  store data; the low bits are used for sub-word stores
o_resp_valid  out  1  response valid
i_resp_ready  in  1  CPU accepts the response
o_resp_rdata  out  32  extended load data; 0 for stores and errors
o_resp_err  out  1  misaligned or illegal-size request
o_mem_addr  out  ADDR_WIDTH  word address to RAM
o_mem_data  out  32  write data to RAM
o_mem_wr_valid  out  1  RAM write request
i_mem_wr_ready  in  1  RAM write accepted
i_mem_data  in  32  RAM read data
i_mem_rd_valid  in  1  RAM read data valid
o_mem_rd_ready  out  1  RAM read request

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE, all outputs 0 except o_req_ready=1. Latched request registers are cleared.
- Reset mid-operation aborts the access; no RAM write is issued after reset asserts.
- States: IDLE, RD_REQ, RD_WAIT, WR, RESP.
- IDLE: o_req_ready=1. On i_req_valid&&o_req_ready, latch addr, we, size, unsigned and wdata.
- Word address = i_req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored.
- o_mem_addr is held constant from accept until return to IDLE.
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - On error go to RESP with err=1, rdata=0. No RAM access.
- Otherwise, next state: load → RD_REQ; word store → WR; byte/half store → RD_REQ (read-modify-write).
- RD_REQ: o_mem_rd_ready=1 for exactly one cycle, then RD_WAIT. rd_ready must never be held for two cycles.
- RD_WAIT: o_mem_rd_ready=0. Wait for i_mem_rd_valid, then capture i_mem_data.
  - Load: lane = addr[1:0] for bytes, addr[1] for halves. Sign-extend unless unsigned; word passes through. Go to RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the captured word at the lane; other bytes unchanged. Go to WR.
- WR: o_mem_wr_valid=1 with o_mem_data stable. Stay in WR until i_mem_wr_ready=1 in the same cycle, then RESP.
- RESP: o_resp_valid=1; rdata and err held stable until i_resp_ready. On the handshake, go to IDLE (o_req_ready=1 the next cycle).
- No overlap: one outstanding request, and no accept in the cycle that completes the response.
- Latency, counted in cycles from the accept edge to o_resp_valid high:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
  - This assumes a RAM that answers rd_ready with rd_valid one cycle later and gives wr_ready in the same cycle.
- Slow RAM: RD_WAIT and WR wait indefinitely, with all mem outputs held.

Test Plan:
- Reset: hold i_rst=0 mid-transfer, including with o_mem_wr_valid=1 → all outputs 0 except o_req_ready=1; state IDLE; RAM word unchanged.
- Word store then load: SW 0x11223344 @0x100, then LW @0x100 → o_mem_addr=0x40, resp_rdata=0x11223344. resp_valid arrives 2 cycles after accept (store) and 3 cycles after accept (load).
- Byte store read-modify-write: word 0x11223344 @0x100, SB 0xAA @0x102 → RAM word 0x11AA3344. Then LB @0x102 → 0xFFFFFFAA; LBU → 0x000000AA.
- Half loads: word 0x8001_7FFE @0x10. LH @0x12 → 0xFFFF8001. LHU @0x12 → 0x00008001. LH @0x10 → 0x00007FFE.
- Misaligned: LW @0x101 → err=1, rdata=0 one cycle after accept, no mem strobe. Same result for SH @0x003 and for size=11.
- Backpressure: hold i_resp_ready=0 for 5 cycles, and delay i_mem_rd_valid and i_mem_wr_ready by 3 cycles → resp_valid, rdata and mem outputs stay stable; o_req_ready=0 throughout; exactly one RAM write per store.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte-addressed CPU loads/stores into word accesses
// on a ready/valid block-RAM port. Loads are lane-extracted and sign- or
// zero-extended; byte/half stores are done as read-modify-write.
// Byte order is little-endian.
module mem_lsu #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // CPU request
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [31:0]           i_req_addr,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  // CPU response
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  // RAM side
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_rd_valid,
  output logic                  o_mem_rd_ready
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;     // word address, held for the whole access
  logic [1:0]              lane_q, lane_d;     // byte offset inside the word
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;   // store data, replaced by the merged word for RMW
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_err;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merged;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_req_addr[31:ADDR_WIDTH+2];

  // Alignment / size legality of the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (i_req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = i_req_addr[0];
      SZ_WORD: req_err = |i_req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Lane extraction, extension and sub-word merge on the returned RAM word.
  always_comb begin
    rd_byte  = i_mem_data[{lane_q, 3'b000} +: 8];
    rd_half  = i_mem_data[{lane_q[1], 4'b0000} +: 16];
    load_val = i_mem_data;
    merged   = i_mem_data;
    case (size_q)
      SZ_BYTE: begin
        load_val = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_val = i_mem_data;
        merged   = i_mem_data;
      end
    endcase
  end

  // Next-state and handshake outputs; one request in flight at a time.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_d        = state_q;
    addr_d         = addr_q;
    lane_d         = lane_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    o_req_ready    = 1'b0;
    o_mem_rd_ready = 1'b0;
    o_mem_wr_valid = 1'b0;
    o_resp_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          addr_d  = i_req_addr[ADDR_WIDTH+1:2];
          lane_d  = i_req_addr[1:0];
          we_d    = i_req_we;
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          wdata_d = i_req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                    state_d = RESP;
          else if (!i_req_we)             state_d = RD_REQ;
          else if (i_req_size == SZ_WORD) state_d = WR;
          else                            state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        o_mem_rd_ready = 1'b1;
        state_d        = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_mem_rd_valid) begin
          if (we_q) begin
            wdata_d = merged;
            state_d = WR;
          end else begin
            rdata_d = load_val;
            state_d = RESP;
          end
        end
      end
      WR: begin
        o_mem_wr_valid = 1'b1;
        if (i_mem_wr_ready) state_d = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_addr   = addr_q;
  assign o_mem_data   = wdata_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a behavioural RAM with programmable
// read/write delays, directed cases plus randomized traffic checked against
// a word-array reference model of the memory.
module tb_mem_lsu;

  localparam int AW = 10;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [AW-1:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_mem_wr_valid;
  logic        i_mem_wr_ready;
  logic [31:0] i_mem_data;
  logic        i_mem_rd_valid;
  logic        o_mem_rd_ready;

  mem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_wdata    (i_req_wdata),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_err     (o_resp_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data     (o_mem_data),
    .o_mem_wr_valid (o_mem_wr_valid),
    .i_mem_wr_ready (i_mem_wr_ready),
    .i_mem_data     (i_mem_data),
    .i_mem_rd_valid (i_mem_rd_valid),
    .o_mem_rd_ready (o_mem_rd_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural RAM ----------------
  logic [31:0] ram     [0:(1<<AW)-1];  // what the DUT actually wrote
  logic [31:0] ref_mem [0:(1<<AW)-1];  // what it should hold
  int rd_delay = 0, wr_delay = 0;
  int wr_count = 0, rd_strobes = 0, rd_double = 0;

  initial begin
    int rd_cnt, wr_wait;
    logic rd_prev, wr_pend;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0] wr_dat;
    rd_cnt = -1; wr_wait = 0; rd_prev = 1'b0; wr_pend = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_dat = '0;
    i_mem_rd_valid = 1'b0; i_mem_wr_ready = 1'b0; i_mem_data = '0;
    forever begin
      @(negedge i_clk);
      // a handshake seen at the previous negedge completed at the posedge between
      if (wr_pend && i_rst) begin
        ram[wr_addr] = wr_dat;
        wr_count++;
      end
      wr_pend = 1'b0;
      if (!i_rst) begin
        rd_cnt = -1; wr_wait = 0; rd_prev = 1'b0;
        i_mem_rd_valid = 1'b0; i_mem_wr_ready = 1'b0;
      end else begin
        i_mem_rd_valid = 1'b0;
        i_mem_data     = $urandom;
        if (rd_cnt == 0) begin
          i_mem_data     = ram[rd_addr];
          i_mem_rd_valid = 1'b1;
          rd_cnt         = -1;
        end else if (rd_cnt > 0) begin
          rd_cnt--;
        end
        if (o_mem_rd_ready) begin
          rd_strobes++;
          if (rd_prev) rd_double++;
          rd_addr = o_mem_addr;
          rd_cnt  = rd_delay;
        end
        rd_prev = o_mem_rd_ready;
        i_mem_wr_ready = 1'b0;
        if (o_mem_wr_valid) begin
          if (wr_wait >= wr_delay) begin
            i_mem_wr_ready = 1'b1;
            wr_pend = 1'b1; wr_addr = o_mem_addr; wr_dat = o_mem_data;
            wr_wait = 0;
          end else begin
            wr_wait++;
          end
        end else begin
          wr_wait = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic is_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
    int sh;
    logic [31:0] v;
    if (size == 2'b10) return word;
    if (size == 2'b00) begin
      sh = int'(addr[1:0]) * 8;
      v  = (word >> sh) & 32'h0000_00ff;
      if (!uns && v[7]) v = v | 32'hffff_ff00;
    end else begin
      sh = int'(addr[1]) * 16;
      v  = (word >> sh) & 32'h0000_ffff;
      if (!uns && v[15]) v = v | 32'hffff_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    int sh;
    logic [31:0] mask;
    if (size == 2'b10) return wdata;
    if (size == 2'b00) begin sh = int'(addr[1:0]) * 8;  mask = 32'h0000_00ff << sh; end
    else               begin sh = int'(addr[1]) * 16;   mask = 32'h0000_ffff << sh; end
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

  logic [31:0] last_rdata;

  // One complete request/response with programmable RAM delays and response hold.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int rd_d, input int wr_d, input int hold);
    logic err_e, sub_st;
    logic [AW-1:0] wa;
    logic [31:0] exp_rdata, exp_word, r_rdata, r_err;
    int exp_lat, lat, waited, wr0, rs0;
    logic addr_bad, data_bad, ready_bad, stable_bad, tmo;
    wa        = addr[AW+1:2];
    err_e     = is_err(size, addr);
    sub_st    = we && size != 2'b10;
    exp_rdata = (err_e || we) ? 32'd0 : ref_load(ref_mem[wa], size, uns, addr);
    exp_word  = ref_store(ref_mem[wa], size, addr, wdata);
    if (err_e)                exp_lat = 1;
    else if (!we)             exp_lat = 3 + rd_d;
    else if (!sub_st)         exp_lat = 2 + wr_d;
    else                      exp_lat = 4 + rd_d + wr_d;
    rd_delay = rd_d; wr_delay = wr_d;
    wr0 = wr_count; rs0 = rd_strobes;
    addr_bad = 0; data_bad = 0; ready_bad = 0; stable_bad = 0; tmo = 0;

    @(negedge i_clk);
    waited = 0;
    while (!o_req_ready && waited < 50) begin @(negedge i_clk); waited++; end
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
    lat = 1;
    while (!o_resp_valid && !tmo) begin
      if (o_mem_addr !== wa) addr_bad = 1;
      if (o_req_ready) ready_bad = 1;
      if (o_mem_wr_valid && o_mem_data !== exp_word) data_bad = 1;
      @(negedge i_clk);
      lat++;
      if (lat > 100) tmo = 1;
    end
    check({tag, ".timeout"}, {31'd0, tmo}, 32'd0);
    r_rdata = o_resp_rdata;
    r_err   = {31'd0, o_resp_err};
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      if (!o_resp_valid || o_resp_rdata !== r_rdata || o_resp_err !== r_err[0] ||
          o_mem_addr !== wa || o_req_ready || o_mem_wr_valid || o_mem_rd_ready) stable_bad = 1;
    end
    i_resp_ready = 1'b1;
    @(negedge i_clk);
    i_resp_ready = 1'b0;
    if (!err_e && we) ref_mem[wa] = exp_word;
    last_rdata = r_rdata;
    check({tag, ".lat"},     lat, exp_lat);
    check({tag, ".rdata"},   r_rdata, exp_rdata);
    check({tag, ".err"},     r_err, {31'd0, err_e});
    check({tag, ".writes"},  wr_count - wr0, (we && !err_e) ? 1 : 0);
    check({tag, ".reads"},   rd_strobes - rs0, (!err_e && (!we || sub_st)) ? 1 : 0);
    check({tag, ".flags"},   {28'd0, addr_bad, data_bad, ready_bad, stable_bad}, 32'd0);
    check({tag, ".idle"},    {30'd0, o_req_ready, o_resp_valid}, 32'd2);
    check({tag, ".ram"},     ram[wa], ref_mem[wa]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ctl"}, {27'd0, o_req_ready, o_resp_valid, o_resp_err, o_mem_wr_valid, o_mem_rd_ready},
          32'h10);
    check({tag, ".data"}, o_resp_rdata | o_mem_data | {22'd0, o_mem_addr}, 32'd0);
  endtask

  // Start an access, assert reset while it waits on the RAM, confirm nothing gets written.
  task automatic reset_mid(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic at_write);
    logic [AW-1:0] wa;
    int wr0, waited;
    logic seen;
    wa = addr[AW+1:2];
    wr0 = wr_count;
    rd_delay = 4; wr_delay = 20;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = size; i_req_unsigned = 1'b0;
    i_req_addr = addr; i_req_wdata = wdata;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    seen = 0; waited = 0;
    while (!seen && waited < 40) begin
      if (at_write ? o_mem_wr_valid : o_mem_rd_ready) seen = 1;
      else begin @(negedge i_clk); waited++; end
    end
    check({tag, ".reached"}, {31'd0, seen}, 32'd1);
    if (!at_write) @(negedge i_clk);  // now waiting for read data
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs(tag);
    repeat (3) @(negedge i_clk);
    check({tag, ".ram"}, ram[wa], ref_mem[wa]);
    check({tag, ".nowr"}, wr_count - wr0, 0);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    check({tag, ".ready"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi, addr;
    logic [AW-1:0] wsel;
    logic [1:0] lane, size;
    int r;
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    i_rst = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_we = 1'b0; i_req_size = '0;
    i_req_unsigned = 1'b0; i_req_wdata = '0; i_resp_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b1;
    @(negedge i_clk);

    // word store then load
    run_req("sw",   1, 2'b10, 0, 32'h100, 32'h1122_3344, 0, 0, 0);
    check("sw.ram_const", ram[10'h40], 32'h1122_3344);
    run_req("lw",   0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 0);
    check("lw.const", last_rdata, 32'h1122_3344);
    // byte RMW
    run_req("sb",   1, 2'b00, 0, 32'h102, 32'hDEAD_BEAA, 0, 0, 0);
    check("sb.ram_const", ram[10'h40], 32'h11AA_3344);
    run_req("lb",   0, 2'b00, 0, 32'h102, 32'h0, 0, 0, 0);
    check("lb.const", last_rdata, 32'hFFFF_FFAA);
    run_req("lbu",  0, 2'b00, 1, 32'h102, 32'h0, 0, 0, 0);
    check("lbu.const", last_rdata, 32'h0000_00AA);
    // half loads
    run_req("sw2",  1, 2'b10, 0, 32'h10, 32'h8001_7FFE, 0, 0, 0);
    run_req("lh_hi",  0, 2'b01, 0, 32'h12, 32'h0, 0, 0, 0);
    check("lh_hi.const", last_rdata, 32'hFFFF_8001);
    run_req("lhu_hi", 0, 2'b01, 1, 32'h12, 32'h0, 0, 0, 0);
    check("lhu_hi.const", last_rdata, 32'h0000_8001);
    run_req("lh_lo",  0, 2'b01, 0, 32'h10, 32'h0, 0, 0, 0);
    check("lh_lo.const", last_rdata, 32'h0000_7FFE);
    // errors
    run_req("lw_mis", 0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 0);
    run_req("sh_mis", 1, 2'b01, 0, 32'h003, 32'h5555_5555, 0, 0, 0);
    run_req("sz11",   0, 2'b11, 0, 32'h100, 32'h0, 0, 0, 0);
    // backpressure on both sides
    run_req("bp_lw", 0, 2'b10, 0, 32'h100, 32'h0, 3, 3, 5);
    run_req("bp_sh", 1, 2'b01, 0, 32'h102, 32'h0000_BEEF, 3, 3, 5);
    run_req("bp_sw", 1, 2'b10, 0, 32'h104, 32'hCAFE_F00D, 3, 3, 5);
    run_req("bp_lb", 0, 2'b00, 0, 32'h103, 32'h0, 3, 3, 5);
    // reset while waiting on RAM
    reset_mid("rst_wr",  2'b10, 32'h200, 32'h0BAD_0BAD, 1);
    reset_mid("rst_rmw", 2'b00, 32'h101, 32'h0000_0077, 0);
    reset_mid("rst_rmw_wr", 2'b01, 32'h102, 32'h0000_1234, 1);
    run_req("post_rst", 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 0);

    // randomized traffic over a small window so accesses collide
    for (int t = 0; t < 120; t++) begin
      hi   = $urandom;
      wsel = AW'($urandom_range(0, 15));
      lane = 2'($urandom_range(0, 3));
      r    = $urandom_range(0, 9);
      size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr = {hi[31-AW-2:0], wsel, lane};
      run_req("rnd", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check("rd_ready_double", rd_double, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
